// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter and the video fetch engine:
//   default RAM geometry and the encoding of the registered read-owner field.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_VID_RD = 2'd2
  } owner_e;

  // Which side's read data will appear on the RAM output next cycle.
  // A CPU write returns nothing, so it records NONE.
  function automatic owner_e next_owner(input logic cpu_gnt,
                                        input logic cpu_wren,
                                        input logic vid_gnt);
    owner_e o;
    o = OWN_NONE;
    if (vid_gnt)
      o = OWN_VID_RD;
    else if (cpu_gnt && !cpu_wren)
      o = OWN_CPU_RD;
    return o;
  endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr
//   Counts consecutive cycles in which video requests but is denied, and
//   raises force_vid once the count reaches STARVE_LIMIT.
//   Ports:
//     clock, reset       system clock, async active-high reset
//     vid_req, vid_gnt   video request and the resulting grant
//     starve_cnt         current denied-cycle count (saturates at the limit)
//     force_vid          video must win arbitration this cycle
module dmem_starve_ctr #(
  parameter int STARVE_LIMIT = 4   // legal range 1..15 (4-bit counter)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vid_req,
  input  logic       vid_gnt,
  output logic [3:0] starve_cnt,
  output logic       force_vid
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      starve_cnt <= 4'd0;
    else if (!vid_req || vid_gnt)
      starve_cnt <= 4'd0;
    else if (starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Gated by reset so the combinational arbitration stays CPU-first while
  // the block is held in reset.
  assign force_vid = vid_req && (starve_cnt == LIMIT) && !reset;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port synchronous RAM between the CPU memory stage and
//   the video/sprite fetch engine. CPU has priority; video is force-granted
//   after STARVE_LIMIT consecutive denied cycles. Read latency is one cycle.
//   Ports:
//     clock, reset                     system clock, async active-high reset
//     cpu_req/cpu_wren/cpu_addr/cpu_data  CPU request side
//     cpu_q, cpu_stall                 CPU read data, hold-request indication
//     vid_req/vid_addr                 video read request
//     vid_gnt, vid_valid, vid_q        video accept, data strobe, read data
//     ram_wEn/ram_addr/ram_dataIn      RAM command
//     ram_dataOut                      RAM read data (one clock after address)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int DATA_W       = DMEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_q,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  logic              cpu_gnt;
  logic              force_vid;
  logic [3:0]        starve_cnt;
  owner_e            owner_p1;
  logic [DATA_W-1:0] cpu_hold_p1;
  logic [DATA_W-1:0] vid_hold_p1;

  dmem_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock      (clock),
    .reset      (reset),
    .vid_req    (vid_req),
    .vid_gnt    (vid_gnt),
    .starve_cnt (starve_cnt),
    .force_vid  (force_vid)
  );

  // ---- stage p0: combinational arbitration and RAM command ----
  assign cpu_gnt    = cpu_req && !force_vid;
  assign vid_gnt    = vid_req && (!cpu_req || force_vid);
  assign cpu_stall  = cpu_req && !cpu_gnt;
  assign ram_wEn    = cpu_req && cpu_wren && cpu_gnt;
  assign ram_addr   = vid_gnt ? vid_addr : cpu_addr;
  assign ram_dataIn = cpu_data;

  // ---- stage p1: read ownership and data hold registers ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_p1    <= OWN_NONE;
      cpu_hold_p1 <= '0;
      vid_hold_p1 <= '0;
    end else begin
      owner_p1 <= next_owner(cpu_gnt, cpu_wren, vid_gnt);
      if (owner_p1 == OWN_CPU_RD)
        cpu_hold_p1 <= ram_dataOut;
      if (owner_p1 == OWN_VID_RD)
        vid_hold_p1 <= ram_dataOut;
    end
  end

  // Owner is cleared by reset, so a grant in flight at reset never surfaces.
  assign vid_valid = (owner_p1 == OWN_VID_RD);
  assign vid_q     = vid_valid ? ram_dataOut : vid_hold_p1;
  assign cpu_q     = (owner_p1 == OWN_CPU_RD) ? ram_dataOut : cpu_hold_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  localparam int K_GNT   = 0;
  localparam int K_STALL = 1;
  localparam int K_WEN   = 2;
  localparam int K_ADDR  = 3;
  localparam int K_CPUQ  = 4;
  localparam int K_VVLD  = 5;
  localparam int K_VIDQ  = 6;
  localparam int K_STRV  = 7;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_wren = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic [DW-1:0] cpu_q;
  logic          cpu_stall;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_gnt;
  logic          vid_valid;
  logic [DW-1:0] vid_q;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn;
  logic [DW-1:0] ram_dataOut = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sq[$];
  logic [31:0] vq[$];

  dmem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_wren    (cpu_wren),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_q       (cpu_q),
    .cpu_stall   (cpu_stall),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_gnt     (vid_gnt),
    .vid_valid   (vid_valid),
    .vid_q       (vid_q),
    .ram_wEn     (ram_wEn),
    .ram_addr    (ram_addr),
    .ram_dataIn  (ram_dataIn),
    .ram_dataOut (ram_dataOut)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous single-port RAM, read-before-write, one-cycle read latency.
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  function automatic string kname(input int k);
    case (k)
      K_GNT:   return "vid_gnt";
      K_STALL: return "cpu_stall";
      K_WEN:   return "ram_wEn";
      K_ADDR:  return "ram_addr";
      K_CPUQ:  return "cpu_q";
      K_VVLD:  return "vid_valid";
      K_VIDQ:  return "vid_q";
      default: return "starve_cnt";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_GNT:   return {31'd0, vid_gnt};
      K_STALL: return {31'd0, cpu_stall};
      K_WEN:   return {31'd0, ram_wEn};
      K_ADDR:  return {20'd0, ram_addr};
      K_CPUQ:  return cpu_q;
      K_VVLD:  return {31'd0, vid_valid};
      K_VIDQ:  return vid_q;
      default: return {28'd0, dut.starve_cnt};
    endcase
  endfunction

  task automatic expect_at(input int c, input int k, input logic [31:0] v);
    exp_t e;
    int   i;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    i = sq.size();
    while (i > 0 && sq[i-1].cyc > c) i--;
    sq.insert(i, e);
  endtask

  task automatic ex(input int k, input logic [31:0] v);
    expect_at(cyc, k, v);
  endtask

  task automatic ex_next(input int k, input logic [31:0] v);
    expect_at(cyc + 1, k, v);
  endtask

  // Arbitration outcome of the current cycle.
  task automatic ex_arb(input logic g, input logic s, input logic w);
    ex(K_GNT, {31'd0, g});
    ex(K_STALL, {31'd0, s});
    ex(K_WEN, {31'd0, w});
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic vr,
                       input logic [AW-1:0] va);
    @(posedge clock);
    #1;
    cpu_req  = cr;
    cpu_wren = cw;
    cpu_addr = ca;
    cpu_data = cd;
    vid_req  = vr;
    vid_addr = va;
  endtask

  // Monitor: video data is checked whenever the DUT strobes vid_valid;
  // cycle-stamped expectations are checked in their cycle.
  always @(negedge clock) begin
    logic [31:0] a;
    exp_t        e;
    logic [31:0] v;
    if (vid_valid === 1'b1) begin
      n_cmp++;
      if (vq.size() == 0) begin
        n_fail++;
        $display("FAIL vid_valid_unexpected cyc=%0d got vid_q=%h, no read outstanding", cyc, vid_q);
      end else begin
        v = vq.pop_front();
        if (vid_q !== v) begin
          n_fail++;
          $display("FAIL vid_read cyc=%0d got %h expected %h", cyc, vid_q, v);
        end
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      e = sq.pop_front();
      a = actual(e.kind);
      n_cmp++;
      if (e.cyc != cyc || a !== e.val) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got %h expected %h", kname(e.kind), e.cyc, a, e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requesters active: CPU-first, nothing in flight.
    drive(1'b1, 1'b0, 12'h055, 32'h0, 1'b1, 12'h020);
    ex_arb(1'b0, 1'b0, 1'b0);
    ex(K_ADDR, 32'h055);
    ex(K_CPUQ, 32'h0);
    ex(K_VVLD, 32'h0);
    ex(K_VIDQ, 32'h0);
    ex(K_STRV, 32'h0);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0);
    reset = 1'b0;
    ex(K_VVLD, 32'h0);

    // CPU writes, then reads back.
    drive(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 12'h0);
    ex_arb(1'b0, 1'b0, 1'b1);
    ex(K_ADDR, 32'h010);
    drive(1'b1, 1'b1, 12'h020, 32'h12345678, 1'b0, 12'h0);
    ex_arb(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 12'h0);
    ex_arb(1'b0, 1'b0, 1'b0);
    ex_next(K_CPUQ, 32'hDEADBEEF);

    // Video-only reads; cpu_q must keep the CPU read value.
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h020);
    ex_arb(1'b1, 1'b0, 1'b0);
    ex(K_ADDR, 32'h020);
    vq.push_back(32'h12345678);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h010);
    ex(K_GNT, 32'h1);
    ex(K_CPUQ, 32'hDEADBEEF);
    vq.push_back(32'hDEADBEEF);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h020);
    ex(K_GNT, 32'h1);
    ex(K_CPUQ, 32'hDEADBEEF);
    ex_next(K_CPUQ, 32'hDEADBEEF);
    vq.push_back(32'h12345678);

    // Contention with CPU writes: video forced in the fifth cycle.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, (k < 4) ? 12'(12'h030 + k) : 12'h034,
            (k < 4) ? 32'(32'h100 + k) : 32'h104, 1'b1, 12'h020);
      ex(K_STRV, (k == 5) ? 32'd0 : 32'(k));
      if (k == 4) begin
        ex_arb(1'b1, 1'b1, 1'b0);
        ex(K_ADDR, 32'h020);
        vq.push_back(32'h12345678);
      end else begin
        ex_arb(1'b0, 1'b0, 1'b1);
      end
    end

    // Video drops after three denied cycles; count restarts from zero.
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 12'h020);
      ex(K_STRV, 32'(k));
      ex_arb(1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 12'h0);
    ex(K_STRV, 32'd3);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 12'h020);
      ex(K_STRV, 32'(k));
      if (k == 4) begin
        ex_arb(1'b1, 1'b1, 1'b0);
        vq.push_back(32'h12345678);
      end else begin
        ex_arb(1'b0, 1'b0, 1'b0);
        ex_next(K_CPUQ, 32'hDEADBEEF);
      end
    end

    // Reset in the cycle after a video grant: its data never surfaces.
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h010);
    ex(K_GNT, 32'h1);
    drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 12'h020);
    #1;
    reset = 1'b1;
    ex(K_VVLD, 32'h0);
    ex(K_CPUQ, 32'h0);
    ex(K_VIDQ, 32'h0);
    ex(K_STRV, 32'h0);
    ex_arb(1'b0, 1'b0, 1'b0);
    // Grant during reset must not produce vid_valid after release.
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h020);
    ex(K_GNT, 32'h1);
    ex(K_VVLD, 32'h0);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h030);
    reset = 1'b0;
    ex(K_VVLD, 32'h0);
    ex(K_GNT, 32'h1);
    vq.push_back(32'h100);

    // Read back contention writes; 0x034 got only the granted write.
    drive(1'b1, 1'b0, 12'h034, 32'h0, 1'b0, 12'h0);
    ex_next(K_CPUQ, 32'h104);
    drive(1'b1, 1'b0, 12'h033, 32'h0, 1'b0, 12'h0);
    ex_next(K_CPUQ, 32'h103);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h031);
    vq.push_back(32'h101);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0);
    ex(K_CPUQ, 32'h103);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0);
    ex(K_CPUQ, 32'h103);
    ex(K_VIDQ, 32'h101);
    repeat (3) @(posedge clock);
    #1;

    n_cmp++;
    if (vq.size() != 0 || sq.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d video reads and %0d checks outstanding, expected 0", vq.size(), sq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
